// File: rtl/fifo_wr_ctrl_wifi.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl_wifi
//
// Write-side pointer and flag controller for the WiFi PHY asynchronous FIFO.
// It runs entirely in the write clock domain. It drives the write port of the
// dual-clock RAM and exports a Gray-coded write pointer to the read domain. It
// also brings the read domain's Gray pointer across through a two-flop
// synchroniser and derives the full, almost-full, level and overflow status
// that the producer uses to throttle its pushes.
//
// Ports
//   W_CLK        in   write-domain clock (the only clock)
//   W_RST        in   asynchronous active-high reset
//   W_INC        in   push request, sampled on posedge W_CLK
//   R_PTR_GRAY   in   Gray read pointer from the read domain (asynchronous)
//   CLR_OVF      in   clears the sticky OVERFLOW flag
//   W_CLK_en     out  RAM write enable (push accepted this cycle)
//   W_Addr       out  RAM write address
//   W_PTR_GRAY   out  registered Gray write pointer for the read domain
//   FULL         out  registered full flag
//   ALMOST_FULL  out  W_LEVEL >= AF_THRESH
//   W_LEVEL      out  write-domain occupancy, 0 .. 2^ADDR_FIFO
//   OVERFLOW     out  sticky: a push was attempted while FULL
// -----------------------------------------------------------------------------
module fifo_wr_ctrl_wifi #(
  parameter int ADDR_FIFO = 4,
  parameter int AF_THRESH = 12
) (
  input  logic                 W_CLK,
  input  logic                 W_RST,
  input  logic                 W_INC,
  input  logic [ADDR_FIFO:0]   R_PTR_GRAY,
  input  logic                 CLR_OVF,
  output logic                 W_CLK_en,
  output logic [ADDR_FIFO-1:0] W_Addr,
  output logic [ADDR_FIFO:0]   W_PTR_GRAY,
  output logic                 FULL,
  output logic                 ALMOST_FULL,
  output logic [ADDR_FIFO:0]   W_LEVEL,
  output logic                 OVERFLOW
);

  localparam int A = ADDR_FIFO;

  // Full is detected in Gray space: the write pointer equals the read pointer
  // with its two most-significant bits inverted (one full lap ahead).
  localparam logic [A:0] FULL_XOR = (A+1)'(3) << (A-1);
  localparam logic [A:0] AF_LVL   = (A+1)'(AF_THRESH);

  logic [A:0] wbin_q,  wbin_d;
  logic [A:0] wgray_q, wgray_d;
  logic [A:0] rq1_q,   rq2_q;
  logic [A:0] rbin_s;
  logic       full_q,  full_d;
  logic       ovf_q,   ovf_d;
  logic       push;

  // The enable is also gated by reset so the RAM is never written while the
  // pointers are being cleared.
  assign push = W_INC & ~full_q & ~W_RST;

  // Gray-to-binary of the synchronised read pointer: bit i is the XOR of all
  // Gray bits at and above i.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    rbin_s = '0;
    for (int i = 0; i <= A; i++) begin
      rbin_s[i] = ^(rq2_q >> i);
    end
  end

  always_comb begin
    wbin_d  = wbin_q + (A+1)'(push);
    wgray_d = wbin_d ^ (wbin_d >> 1);
    // Looking at the post-push pointer makes FULL rise on the same edge as the
    // push that fills the last entry, so the producer can never overrun.
    full_d  = (wgray_d == (rq2_q ^ FULL_XOR));
    // Set has priority over clear so a fresh overflow is never lost.
    if (W_INC && full_q) begin
      ovf_d = 1'b1;
    end else if (CLR_OVF) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge W_CLK or posedge W_RST) begin
    if (W_RST) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      rq1_q   <= '0;
      rq2_q   <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge; rq2 must take the old rq1, not the new one.
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      rq1_q   <= R_PTR_GRAY;
      rq2_q   <= rq1_q;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

  assign W_CLK_en    = push;
  assign W_Addr      = wbin_q[A-1:0];
  assign W_PTR_GRAY  = wgray_q;
  assign FULL        = full_q;
  assign OVERFLOW    = ovf_q;
  // The synchronised read pointer lags the real one, so this level can only
  // over-estimate the occupancy, which is the safe direction for a writer.
  assign W_LEVEL     = wbin_q - rbin_s;
  assign ALMOST_FULL = (W_LEVEL >= AF_LVL);

endmodule

// File: tb/tb_fifo_wr_ctrl_wifi.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_ctrl_wifi
//
// Directed bench for fifo_wr_ctrl_wifi (ADDR_FIFO=4, AF_THRESH=12): fill to
// full, overflow and its clear, read-side release through the synchroniser,
// long wrap-around with a trailing read pointer, and asynchronous reset in the
// middle of a burst. Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_fifo_wr_ctrl_wifi;

  logic       W_CLK = 1'b0;
  logic       W_RST = 1'b0;
  logic       W_INC = 1'b0;
  logic [4:0] R_PTR_GRAY = '0;
  logic       CLR_OVF = 1'b0;
  logic       W_CLK_en;
  logic [3:0] W_Addr;
  logic [4:0] W_PTR_GRAY;
  logic       FULL;
  logic       ALMOST_FULL;
  logic [4:0] W_LEVEL;
  logic       OVERFLOW;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_wr_ctrl_wifi #(.ADDR_FIFO(4), .AF_THRESH(12)) dut (
    .W_CLK      (W_CLK),
    .W_RST      (W_RST),
    .W_INC      (W_INC),
    .R_PTR_GRAY (R_PTR_GRAY),
    .CLR_OVF    (CLR_OVF),
    .W_CLK_en   (W_CLK_en),
    .W_Addr     (W_Addr),
    .W_PTR_GRAY (W_PTR_GRAY),
    .FULL       (FULL),
    .ALMOST_FULL(ALMOST_FULL),
    .W_LEVEL    (W_LEVEL),
    .OVERFLOW   (OVERFLOW)
  );

  always #5 W_CLK = ~W_CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge W_CLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"},  32'(W_Addr),      0);
    check({tag, "_en"},    32'(W_CLK_en),    0);
    check({tag, "_gray"},  32'(W_PTR_GRAY),  0);
    check({tag, "_full"},  32'(FULL),        0);
    check({tag, "_af"},    32'(ALMOST_FULL), 0);
    check({tag, "_level"}, 32'(W_LEVEL),     0);
    check({tag, "_ovf"},   32'(OVERFLOW),    0);
  endtask

  task automatic do_reset();
    W_RST = 1'b1;
    #2;
    W_RST = 1'b0;
    #1;
  endtask

  initial begin
    int         wraps;
    int         rp;
    int         r_last;
    logic [3:0] prev_addr;
    logic [4:0] prev_gray;

    // ---------------- reset ----------------
    #1 W_RST = 1'b1;
    #1 check_all_zero("rst_async");
    tick();
    tick();
    check_all_zero("rst_held");
    W_RST = 1'b0;

    // ---------------- 1: fill 16 entries ----------------
    W_INC = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("fill_addr", 32'(W_Addr), 32'(i));
      check("fill_en",   32'(W_CLK_en), 1);
      tick();
      check("fill_level", 32'(W_LEVEL),     32'(i + 1));
      check("fill_af",    32'(ALMOST_FULL), (i + 1 >= 12) ? 1 : 0);
      check("fill_full",  32'(FULL),        (i + 1 == 16) ? 1 : 0);
    end
    check("fill_gray", 32'(W_PTR_GRAY), 32'(5'b11000));

    // ---------------- 2: push while full ----------------
    check("ovf_en",   32'(W_CLK_en), 0);
    check("ovf_addr", 32'(W_Addr),   0);
    tick();
    check("ovf_set",        32'(OVERFLOW),   1);
    check("ovf_addr_hold",  32'(W_Addr),     0);
    check("ovf_gray_hold",  32'(W_PTR_GRAY), 32'(5'b11000));
    check("ovf_level_hold", 32'(W_LEVEL),    16);
    W_INC = 1'b0; CLR_OVF = 1'b1;
    tick();
    check("ovf_clear", 32'(OVERFLOW), 0);

    // ---------------- 6: clear and new overflow together ----------------
    W_INC = 1'b1; CLR_OVF = 1'b1;
    tick();
    check("ovf_set_wins", 32'(OVERFLOW), 1);
    W_INC = 1'b0; CLR_OVF = 1'b1;
    tick();
    check("ovf_clear2", 32'(OVERFLOW), 0);
    CLR_OVF = 1'b0;

    // ---------------- 3: one read releases one slot ----------------
    W_INC = 1'b1;
    R_PTR_GRAY = 5'b00001;
    tick();  // edge n
    check("rd_n_level", 32'(W_LEVEL), 16);
    check("rd_n_full",  32'(FULL),    1);
    tick();  // edge n+1
    check("rd_n1_level", 32'(W_LEVEL),  15);
    check("rd_n1_full",  32'(FULL),     1);
    check("rd_n1_en",    32'(W_CLK_en), 0);
    tick();  // edge n+2
    check("rd_n2_full", 32'(FULL),     0);
    check("rd_n2_en",   32'(W_CLK_en), 1);
    check("rd_n2_addr", 32'(W_Addr),   0);
    tick();  // edge n+3: push accepted, full again
    check("rd_n3_full",  32'(FULL),       1);
    check("rd_n3_level", 32'(W_LEVEL),    16);
    check("rd_n3_gray",  32'(W_PTR_GRAY), 32'(5'b11001));
    check("rd_n3_addr",  32'(W_Addr),     1);
    W_INC = 1'b0; CLR_OVF = 1'b1;
    tick();
    CLR_OVF = 1'b0;
    check("rd_ovf_clear", 32'(OVERFLOW), 0);

    // ---------------- 4: wrap with read pointer trailing by 3 ----------------
    R_PTR_GRAY = '0;
    do_reset();
    wraps = 0;
    r_last = 0;
    prev_addr = 4'd0;
    prev_gray = 5'd0;
    for (int n = 0; n < 40; n++) begin
      rp = (n >= 3) ? ((n - 3) % 32) : 0;
      R_PTR_GRAY = gray(5'(rp));
      W_INC = 1'b1;
      #1;
      check("wrap_addr", 32'(W_Addr),   32'(n % 16));
      check("wrap_en",   32'(W_CLK_en), 1);
      if (n > 0 && prev_addr == 4'd15 && W_Addr == 4'd0) wraps++;
      prev_addr = W_Addr;
      tick();
      check("wrap_gray",    32'(W_PTR_GRAY), 32'(gray(5'((n + 1) % 32))));
      check("wrap_gray1b",  32'($countones(W_PTR_GRAY ^ prev_gray)), 1);
      check("wrap_full",    32'(FULL), 0);
      check("wrap_level",   32'(W_LEVEL), 32'((n + 1 - r_last) & 31));
      prev_gray = W_PTR_GRAY;
      r_last = rp;
    end
    check("wrap_count",       32'(wraps),   2);
    check("wrap_level_final", 32'(W_LEVEL), 5);
    W_INC = 1'b0;

    // ---------------- 5: async reset mid-burst ----------------
    R_PTR_GRAY = '0;
    do_reset();
    W_INC = 1'b1;
    repeat (7) tick();
    W_INC = 1'b0;
    check("mr_addr7", 32'(W_Addr), 7);
    // Read pointer one lap behind makes the 7-entry write pointer look full.
    R_PTR_GRAY = gray(5'd23);
    tick();
    tick();
    check("mr_level16", 32'(W_LEVEL), 16);
    tick();
    check("mr_full", 32'(FULL), 1);
    W_INC = 1'b1;
    tick();
    check("mr_ovf",       32'(OVERFLOW), 1);
    check("mr_addr_hold", 32'(W_Addr),   7);
    W_INC = 1'b0;
    R_PTR_GRAY = '0;
    repeat (3) tick();
    check("mr_notfull", 32'(FULL),     0);
    check("mr_level7",  32'(W_LEVEL),  7);
    check("mr_ovf_hold", 32'(OVERFLOW), 1);
    W_INC = 1'b1;
    #1;
    check("mr_pre_en",   32'(W_CLK_en), 1);
    check("mr_pre_addr", 32'(W_Addr),   7);
    #1 W_RST = 1'b1;
    #1 check_all_zero("mr_rst");
    #1 W_RST = 1'b0;
    #1;
    check("mr_post_addr", 32'(W_Addr),   0);
    check("mr_post_en",   32'(W_CLK_en), 1);
    tick();
    check("mr_post_addr1", 32'(W_Addr),     1);
    check("mr_post_gray",  32'(W_PTR_GRAY), 1);
    check("mr_post_level", 32'(W_LEVEL),    1);
    W_INC = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
